// File: rtl/alu_pkg.sv
// Shared ALU control codes and FSM encoding for the multicycle ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_MULT = 3'b101;
  localparam logic [2:0] ALU_DIV  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the control FSM (master) and the ALU (slave).
interface multicycle_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, alu_control, a, b,
    input  result, result_hi, zero, busy, done, div_by_zero
  );

  modport slave (
    input  start, alu_control, a, b,
    output result, result_hi, zero, busy, done, div_by_zero
  );
endinterface

// File: rtl/alu_iter_core.sv
// Unsigned shift-add multiplier and restoring divider sharing one accumulator/shift pair.
// lo/hi present the values after the current step so the parent can capture the final step.
module alu_iter_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             run_q, run_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    acc_d    = acc_q;
    sr_d     = sr_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    run_d    = run_q;
    cnt_d    = cnt_q;
    addend   = sr_q[0] ? opnd_q : '0;
    sum      = {1'b0, acc_q} + {1'b0, addend};
    shifted  = {acc_q, sr_q[WIDTH-1]};
    diff     = shifted - {1'b0, opnd_q};
    if (load) begin
      // Divide: shift register holds the dividend; multiply: it holds the multiplier.
      acc_d    = '0;
      sr_d     = is_div ? a : b;
      opnd_d   = is_div ? b : a;
      is_div_d = is_div;
      run_d    = 1'b1;
      cnt_d    = '0;
    end else if (run_q) begin
      if (is_div_q) begin
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          sr_d  = {sr_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = sum[WIDTH:1];
        sr_d  = {sum[0], sr_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      sr_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      run_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      sr_q     <= sr_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
    end
  end

  // Low during the final step, telling the parent to capture lo/hi at this edge.
  assign busy = run_q && (cnt_q != CW'(WIDTH - 1));
  assign lo   = sr_d;
  assign hi   = acc_d;
endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative MULT/DIV behind a start/busy/done handshake.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_alu_if.slave   bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             iterative;
  logic             div_zero;
  logic             core_load;
  logic             core_busy;
  logic [WIDTH-1:0] core_lo, core_hi;
  logic [WIDTH-1:0] simple_res;

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (core_load),
    .is_div (bus.alu_control == ALU_DIV),
    .a      (bus.a),
    .b      (bus.b),
    .busy   (core_busy),
    .lo     (core_lo),
    .hi     (core_hi)
  );

  assign accept    = bus.start && (state_q != ST_ITER);
  assign div_zero  = (bus.alu_control == ALU_DIV) && (bus.b == '0);
  assign iterative = (bus.alu_control == ALU_MULT) ||
                     ((bus.alu_control == ALU_DIV) && (bus.b != '0));
  assign core_load = accept && iterative;

  always_comb begin
    case (bus.alu_control)
      ALU_SUB: simple_res = bus.a - bus.b;
      ALU_AND: simple_res = bus.a & bus.b;
      ALU_OR:  simple_res = bus.a | bus.b;
      ALU_SLT: simple_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      default: simple_res = bus.a + bus.b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ITER: state_d = core_busy ? ST_ITER : ST_DONE;
      default: begin
        if (accept) begin
          state_d = iterative ? ST_ITER : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    result_d    = result_q;
    result_hi_d = result_hi_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    busy_d      = (state_d == ST_ITER);
    if (state_q == ST_ITER) begin
      if (!core_busy) begin
        result_d    = core_lo;
        result_hi_d = core_hi;
        dbz_d       = 1'b0;
        done_d      = 1'b1;
      end
    end else if (accept && !iterative) begin
      done_d = 1'b1;
      if (div_zero) begin
        result_d    = '1;
        result_hi_d = bus.a;
        dbz_d       = 1'b1;
      end else begin
        result_d    = simple_res;
        result_hi_d = '0;
        dbz_d       = 1'b0;
      end
    end
    // result only changes on completion, so zero can track it unconditionally.
    zero_d = (result_d == '0);
  end

  assign bus.result      = result_q;
  assign bus.result_hi   = result_hi_q;
  assign bus.zero        = zero_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule
